// File: rtl/rtr_ivc_route_state_pkg.sv
// Shared definitions for the per-input-VC route/allocation state tracker:
// state encoding, error bit positions and the raw-state decode.
package rtr_ivc_route_state_pkg;

    localparam int VC_STATE_WIDTH = 2;

    typedef enum logic [VC_STATE_WIDTH-1:0] {
        VC_STATE_IDLE   = 2'd0,
        VC_STATE_VA     = 2'd1,
        VC_STATE_ACTIVE = 2'd2
    } vc_state_e;

    localparam int ERR_WIDTH     = 4;
    localparam int ERR_HDR_UNEXP = 0;
    localparam int ERR_GNT_UNEXP = 1;
    localparam int ERR_OVC_BAD   = 2;
    localparam int ERR_ROUTE_BAD = 3;

    // Encoding 3 is unreachable; should it ever appear it behaves as IDLE.
    function automatic vc_state_e decode_state(input logic [VC_STATE_WIDTH-1:0] raw);
        case (raw)
            2'd1:    return VC_STATE_VA;
            2'd2:    return VC_STATE_ACTIVE;
            default: return VC_STATE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtr_ivc_route_state_ovc_class_check.sv
// Checks that a granted output VC is one-hot, belongs to this VC's message
// class, and falls in a resource class the route filter allowed.
module rtr_ivc_route_state_ovc_class_check
    import rtr_ivc_route_state_pkg::*;
#(
    parameter int num_message_classes  = 2,
    parameter int num_resource_classes = 2,
    parameter int num_vcs_per_class    = 1,
    parameter int vc_id                = 0
) (
    input  logic [num_message_classes*num_resource_classes*num_vcs_per_class-1:0] ovc,
    input  logic [num_resource_classes-1:0]                                       orc,
    output logic                                                                  ovc_bad
);

    localparam int num_vcs = num_message_classes * num_resource_classes * num_vcs_per_class;
    localparam int this_mc = (vc_id / (num_resource_classes * num_vcs_per_class)) % num_message_classes;

    int   hot_count;
    logic mc_ok;
    logic rc_ok;

    // Class indices follow the same packing as vc_id: vcs inside rc inside mc.
    always_comb begin
        hot_count = 0;
        mc_ok     = 1'b0;
        rc_ok     = 1'b0;
        for (int v = 0; v < num_vcs; v++) begin
            if (ovc[v]) begin
                hot_count = hot_count + 1;
                if (((v / (num_resource_classes * num_vcs_per_class)) % num_message_classes) == this_mc)
                    mc_ok = 1'b1;
                if (orc[(v / num_vcs_per_class) % num_resource_classes])
                    rc_ok = 1'b1;
            end
        end
        ovc_bad = (hot_count != 1) || !mc_ok || !rc_ok;
    end

endmodule

// File: rtl/rtr_ivc_route_state.sv
// Per-input-VC route/allocation state: captures the filtered route on a head
// flit, requests and holds an output VC, releases it when the tail departs.
module rtr_ivc_route_state
    import rtr_ivc_route_state_pkg::*;
#(
    parameter int num_message_classes  = 2,
    parameter int num_resource_classes = 2,
    parameter int num_vcs_per_class    = 1,
    parameter int num_ports            = 5,
    parameter int port_id              = 0,
    parameter int vc_id                = 0
) (
    input  logic                                                                  clk,
    input  logic                                                                  reset,
    input  logic                                                                  hdr_valid,
    input  logic [num_ports-1:0]                                                  route_op,
    input  logic [num_resource_classes-1:0]                                       route_orc,
    input  logic                                                                  va_gnt,
    input  logic [num_message_classes*num_resource_classes*num_vcs_per_class-1:0] va_gnt_ovc,
    input  logic                                                                  sa_gnt,
    input  logic                                                                  sa_gnt_tail,
    output logic                                                                  va_req,
    output logic [num_ports-1:0]                                                  va_req_op,
    output logic [num_resource_classes-1:0]                                       va_req_orc,
    output logic                                                                  active,
    output logic [num_message_classes*num_resource_classes*num_vcs_per_class-1:0] alloc_ovc,
    output logic [ERR_WIDTH-1:0]                                                  errors
);

    localparam int num_vcs = num_message_classes * num_resource_classes * num_vcs_per_class;

    if (port_id >= num_ports || vc_id >= num_vcs) begin : g_bad_config
        $error("rtr_ivc_route_state: port_id or vc_id out of range");
    end

    logic [VC_STATE_WIDTH-1:0]       state_q;
    vc_state_e                       state;
    vc_state_e                       state_d;
    logic [num_ports-1:0]            op_q;
    logic [num_resource_classes-1:0] orc_q;
    logic [num_vcs-1:0]              ovc_q;
    logic                            latch_route;
    logic                            latch_ovc;
    logic                            clear_pkt;
    logic                            ovc_bad;
    int                              op_hot_count;

    assign state = decode_state(state_q);

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= VC_STATE_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset || clear_pkt) begin
            op_q  <= '0;
            orc_q <= '0;
            ovc_q <= '0;
        end else begin
            if (latch_route) begin
                op_q  <= route_op;
                orc_q <= route_orc;
            end
            if (latch_ovc)
                ovc_q <= va_gnt_ovc;
        end
    end

    // Grants arriving in the wrong state are reported but never move the FSM.
    always_comb begin
        state_d     = state;
        latch_route = 1'b0;
        latch_ovc   = 1'b0;
        clear_pkt   = 1'b0;
        case (state)
            VC_STATE_IDLE: begin
                if (hdr_valid) begin
                    state_d     = VC_STATE_VA;
                    latch_route = 1'b1;
                end
            end
            VC_STATE_VA: begin
                if (va_gnt) begin
                    state_d   = VC_STATE_ACTIVE;
                    latch_ovc = 1'b1;
                end
            end
            VC_STATE_ACTIVE: begin
                if (sa_gnt && sa_gnt_tail) begin
                    state_d   = VC_STATE_IDLE;
                    clear_pkt = 1'b1;
                end
            end
            default: state_d = VC_STATE_IDLE;
        endcase
    end

    rtr_ivc_route_state_ovc_class_check #(
        .num_message_classes (num_message_classes),
        .num_resource_classes(num_resource_classes),
        .num_vcs_per_class   (num_vcs_per_class),
        .vc_id               (vc_id)
    ) u_ovc_check (
        .ovc    (va_gnt_ovc),
        .orc    (orc_q),
        .ovc_bad(ovc_bad)
    );

    always_comb begin
        va_req     = (state == VC_STATE_VA);
        active     = (state == VC_STATE_ACTIVE);
        va_req_op  = op_q;
        va_req_orc = orc_q;
        alloc_ovc  = ovc_q;
    end

    // Error flags are purely combinational and silenced while reset is held.
    always_comb begin
        op_hot_count = 0;
        for (int p = 0; p < num_ports; p++) begin
            if (route_op[p])
                op_hot_count = op_hot_count + 1;
        end
        errors = '0;
        if (!reset) begin
            errors[ERR_HDR_UNEXP] = hdr_valid && (state != VC_STATE_IDLE);
            errors[ERR_GNT_UNEXP] = (va_gnt && (state != VC_STATE_VA)) ||
                                    (sa_gnt && (state != VC_STATE_ACTIVE));
            errors[ERR_OVC_BAD]   = va_gnt && (state == VC_STATE_VA) && ovc_bad;
            errors[ERR_ROUTE_BAD] = hdr_valid && (state == VC_STATE_IDLE) &&
                                    ((op_hot_count != 1) || (route_orc == '0));
        end
    end

endmodule

// File: tb/tb_rtr_ivc_route_state.sv
// Scoreboard bench: a packet-level model predicts every cycle's outputs,
// a negedge monitor pops the prediction and compares it with the DUT.
module tb_rtr_ivc_route_state;

    typedef struct packed {
        logic       va_req;
        logic [4:0] op;
        logic [1:0] orc;
        logic       active;
        logic [3:0] ovc;
        logic [3:0] err;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hdr_valid = 1'b0;
    logic [4:0] route_op = '0;
    logic [1:0] route_orc = '0;
    logic       va_gnt = 1'b0;
    logic [3:0] va_gnt_ovc = '0;
    logic       sa_gnt = 1'b0;
    logic       sa_gnt_tail = 1'b0;
    logic       va_req;
    logic [4:0] va_req_op;
    logic [1:0] va_req_orc;
    logic       active;
    logic [3:0] alloc_ovc;
    logic [3:0] errors;

    int    checks = 0;
    int    fails  = 0;
    snap_t exp_q[$];

    // Packet-level reference: is a route captured, is an output VC held.
    bit         pkt_open = 1'b0;
    bit         vc_held  = 1'b0;
    logic [4:0] m_op  = '0;
    logic [1:0] m_orc = '0;
    logic [3:0] m_ovc = '0;

    rtr_ivc_route_state dut (
        .clk        (clk),
        .reset      (reset),
        .hdr_valid  (hdr_valid),
        .route_op   (route_op),
        .route_orc  (route_orc),
        .va_gnt     (va_gnt),
        .va_gnt_ovc (va_gnt_ovc),
        .sa_gnt     (sa_gnt),
        .sa_gnt_tail(sa_gnt_tail),
        .va_req     (va_req),
        .va_req_op  (va_req_op),
        .va_req_orc (va_req_orc),
        .active     (active),
        .alloc_ovc  (alloc_ovc),
        .errors     (errors)
    );

    always #5 clk = ~clk;

    // This VC is mc=0; VC index i has mc=(i/2)%2 and rc=i%2.
    function automatic bit ovc_is_bad(input logic [3:0] ovc, input logic [1:0] orc);
        int idx;
        if ($countones(ovc) != 1) return 1'b1;
        idx = 0;
        for (int i = 0; i < 4; i++) if (ovc[i]) idx = i;
        if (((idx / 2) % 2) != 0) return 1'b1;
        return ((orc >> (idx % 2)) & 2'b01) == 2'b00;
    endfunction

    task automatic applyStimulus(input bit rst, input bit h, input logic [4:0] op,
                                 input logic [1:0] orc, input bit vg, input logic [3:0] ovc,
                                 input bit sg, input bit tail);
        snap_t e;
        bit    waiting_vc;
        @(posedge clk);
        #1;
        reset = rst; hdr_valid = h; route_op = op; route_orc = orc;
        va_gnt = vg; va_gnt_ovc = ovc; sa_gnt = sg; sa_gnt_tail = tail;
        waiting_vc = pkt_open && !vc_held;
        e.va_req = waiting_vc;
        e.op     = m_op;
        e.orc    = m_orc;
        e.active = vc_held;
        e.ovc    = m_ovc;
        e.err    = '0;
        if (!rst) begin
            e.err[0] = h && pkt_open;
            e.err[1] = (vg && !waiting_vc) || (sg && !vc_held);
            e.err[2] = vg && waiting_vc && ovc_is_bad(ovc, m_orc);
            e.err[3] = h && !pkt_open && (($countones(op) != 1) || (orc == 2'b00));
        end
        exp_q.push_back(e);
        if (rst) begin
            pkt_open = 0; vc_held = 0; m_op = '0; m_orc = '0; m_ovc = '0;
        end else if (!pkt_open && h) begin
            pkt_open = 1; m_op = op; m_orc = orc;
        end else if (waiting_vc && vg) begin
            vc_held = 1; m_ovc = ovc;
        end else if (vc_held && sg && tail) begin
            pkt_open = 0; vc_held = 0; m_op = '0; m_orc = '0; m_ovc = '0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, '0, 0, 0);
    endtask

    task automatic checkOutput(input snap_t e);
        snap_t a;
        a = '{va_req, va_req_op, va_req_orc, active, alloc_ovc, errors};
        checks++;
        if (a !== e) begin
            fails++;
            $display("[TB] FAIL cycle_outputs t=%0t got va_req=%b op=%b orc=%b active=%b ovc=%b err=%b expected va_req=%b op=%b orc=%b active=%b ovc=%b err=%b",
                     $time, a.va_req, a.op, a.orc, a.active, a.ovc, a.err,
                     e.va_req, e.op, e.orc, e.active, e.ovc, e.err);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        repeat (2) @(posedge clk);
        applyStimulus(1, 0, '0, '0, 0, '0, 0, 0);
        idle(1);

        // Multi-flit packet: head, grant after three request cycles, tail on third flit.
        applyStimulus(0, 1, 5'b00100, 2'b11, 0, '0, 0, 0);
        idle(2);
        applyStimulus(0, 0, '0, '0, 1, 4'b0010, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 1, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 1, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 1, 1);
        idle(2);

        // Single-flit packet followed by a back-to-back head.
        applyStimulus(0, 1, 5'b01000, 2'b01, 0, '0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 4'b0001, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 1, 1);
        applyStimulus(0, 1, 5'b00001, 2'b10, 0, '0, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 0, 0);

        // Bad output VCs: wrong message class, then not one-hot.
        applyStimulus(0, 0, '0, '0, 1, 4'b0100, 0, 0);
        applyStimulus(1, 0, '0, '0, 0, '0, 0, 0);
        applyStimulus(0, 1, 5'b00010, 2'b11, 0, '0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 4'b0011, 0, 0);

        // Unexpected head in ACTIVE, then tail, then sa_gnt in IDLE.
        applyStimulus(0, 1, 5'b10000, 2'b01, 0, '0, 0, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 1, 1);
        applyStimulus(0, 0, '0, '0, 0, '0, 1, 1);
        idle(1);

        // Reset mid-packet while the switch grant is asserted.
        applyStimulus(0, 1, 5'b00100, 2'b01, 0, '0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 4'b0001, 0, 0);
        applyStimulus(1, 0, '0, '0, 0, '0, 1, 0);
        idle(1);

        // Malformed route is flagged but still captured.
        applyStimulus(0, 1, 5'b00110, 2'b01, 0, '0, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 4'b0010, 1, 0);
        applyStimulus(0, 0, '0, '0, 0, '0, 1, 1);
        idle(1);

        for (int i = 0; i < 1500; i++) begin
            logic [4:0] op;
            logic [3:0] ovc;
            op  = ($urandom_range(0, 99) < 85) ? 5'(5'b00001 << $urandom_range(0, 4))
                                                : 5'($urandom_range(0, 31));
            ovc = ($urandom_range(0, 99) < 85) ? 4'(4'b0001 << $urandom_range(0, 3))
                                                : 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 35, op,
                          2'($urandom_range(0, 3)), $urandom_range(0, 99) < 35, ovc,
                          $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1);
        end

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, fails);
        $finish;
    end

endmodule
